// File: rtl/pingpong_frame_reader_pkg.sv
// Shared types and defaults for the ping-pong frame reader.
package pingpong_frame_reader_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_DEPTH     = 256;
    localparam int DEFAULT_CNT_WIDTH = 8;

    // Skid buffer holds at most two words: one being presented, one landing.
    localparam logic [1:0] SKID_FULL = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } reader_state_t;

    // A read may be issued only while the words already held plus the word
    // still in flight leave room in the skid buffer for the new one.
    function automatic logic credit_available(input logic [1:0] fifo_count,
                                              input logic       inflight);
        return ({1'b0, fifo_count} + {2'b00, inflight}) < {1'b0, SKID_FULL};
    endfunction

endpackage

// File: rtl/pingpong_frame_reader_if.sv
// Buffer-read and downstream-stream signals of the frame reader.
// The master modport is the reader's view; slave is the environment's view.
interface pingpong_frame_reader_if
    import pingpong_frame_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic signed [WIDTH-1:0] rd_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic signed [WIDTH-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_first;
    logic                    m_last;

    modport master (
        input  rd_data, rd_valid, m_ready,
        output rd_ready, m_data, m_valid, m_first, m_last
    );

    modport slave (
        output rd_data, rd_valid, m_ready,
        input  rd_ready, m_data, m_valid, m_first, m_last
    );
endinterface

// File: rtl/pingpong_frame_reader_skid.sv
// Two-entry FIFO carrying {data, word index}. The head entry is held in
// dedicated registers so the downstream outputs come straight from flops.
module ram_rd_skid_buffer
    import pingpong_frame_reader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int IDX_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic signed [WIDTH-1:0] push_data_i,
    input  logic [IDX_WIDTH-1:0]    push_idx_i,
    input  logic                    pop_i,
    output logic signed [WIDTH-1:0] head_data_o,
    output logic [IDX_WIDTH-1:0]    head_idx_o,
    output logic                    valid_o,
    output logic [1:0]              count_o
);

    logic signed [WIDTH-1:0] head_data_q, head_data_d;
    logic signed [WIDTH-1:0] tail_data_q, tail_data_d;
    logic [IDX_WIDTH-1:0]    head_idx_q, head_idx_d;
    logic [IDX_WIDTH-1:0]    tail_idx_q, tail_idx_d;
    logic [1:0]              count_q, count_d;
    logic                    valid_q, valid_d;
    logic                    pop_ok_s;
    logic                    push_ok_s;

    // Next-state of the FIFO: clear wins, otherwise shift head/tail per push/pop.
    always_comb begin
        head_data_d = head_data_q;
        tail_data_d = tail_data_q;
        head_idx_d  = head_idx_q;
        tail_idx_d  = tail_idx_q;
        count_d     = count_q;
        pop_ok_s    = pop_i & valid_q;
        push_ok_s   = push_i & ((count_q != SKID_FULL) | pop_ok_s);

        if (clear_i) begin
            head_data_d = '0;
            tail_data_d = '0;
            head_idx_d  = '0;
            tail_idx_d  = '0;
            count_d     = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_data_d = push_data_i;
                        head_idx_d  = push_idx_i;
                    end else begin
                        tail_data_d = push_data_i;
                        tail_idx_d  = push_idx_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_data_d = tail_data_q;
                    head_idx_d  = tail_idx_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_data_d = push_data_i;
                        head_idx_d  = push_idx_i;
                    end else begin
                        head_data_d = tail_data_q;
                        head_idx_d  = tail_idx_q;
                        tail_data_d = push_data_i;
                        tail_idx_d  = push_idx_i;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        valid_d = (count_d != 2'd0);
    end

    // FIFO storage and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_data_q <= '0;
            tail_data_q <= '0;
            head_idx_q  <= '0;
            tail_idx_q  <= '0;
            count_q     <= 2'd0;
            valid_q     <= 1'b0;
        end else begin
            head_data_q <= head_data_d;
            tail_data_q <= tail_data_d;
            head_idx_q  <= head_idx_d;
            tail_idx_q  <= tail_idx_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
        end
    end

    assign head_data_o = head_data_q;
    assign head_idx_o  = head_idx_q;
    assign valid_o     = valid_q;
    assign count_o     = count_q;

endmodule

// File: rtl/pingpong_frame_reader.sv
// Consumer end of the ping-pong sample buffer: after each buffer-ready pulse
// it reads one frame of DEPTH words, absorbs the one-cycle RAM read latency
// through a two-entry skid buffer, and streams words out with first/last
// markers. A new pulse before the frame has drained is counted as an overrun
// and restarts reading at word 0.
module pingpong_frame_reader
    import pingpong_frame_reader_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    buffer_ready_i,
    pingpong_frame_reader_if.master bus,
    output logic                    busy_o,
    output logic [CNT_WIDTH-1:0]    frame_count_o,
    output logic [CNT_WIDTH-1:0]    overrun_count_o,
    output logic                    overrun_o
);

    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [IW-1:0]         FRAME_WORDS = IW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = {CNT_WIDTH{1'b1}};

    reader_state_t           state_q, state_d;
    logic [IW-1:0]           issued_q, issued_d;
    logic [IW-1:0]           emitted_q, emitted_d;
    logic                    inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]   inflight_idx_q, inflight_idx_d;
    logic [CNT_WIDTH-1:0]    frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0]    overrun_count_q, overrun_count_d;
    logic                    overrun_q, overrun_d;

    logic signed [WIDTH-1:0] head_data_s;
    logic [ADDR_WIDTH-1:0]   head_idx_s;
    logic                    head_valid_s;
    logic [1:0]              fifo_count_s;
    logic                    skid_clear_s;
    logic                    rd_ready_s;
    logic                    rd_acc_s;
    logic                    m_acc_s;
    logic [IW-1:0]           emitted_next_s;
    logic                    fifo_drains_s;
    logic                    flush_done_s;
    logic                    overrun_s;

    ram_rd_skid_buffer #(
        .WIDTH     (WIDTH),
        .IDX_WIDTH (ADDR_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (skid_clear_s),
        .push_i      (inflight_q),
        .push_data_i (bus.rd_data),
        .push_idx_i  (inflight_idx_q),
        .pop_i       (m_acc_s),
        .head_data_o (head_data_s),
        .head_idx_o  (head_idx_s),
        .valid_o     (head_valid_s),
        .count_o     (fifo_count_s)
    );

    // Handshake qualifiers and the frame-complete / overrun decisions.
    always_comb begin
        rd_ready_s     = (state_q == DRAIN) & (issued_q < FRAME_WORDS) &
                         credit_available(fifo_count_s, inflight_q);
        rd_acc_s       = bus.rd_valid & rd_ready_s;
        m_acc_s        = head_valid_s & bus.m_ready;
        emitted_next_s = emitted_q + {{ADDR_WIDTH{1'b0}}, m_acc_s};
        // The skid buffer is empty after this cycle when nothing lands and
        // the only held word (if any) leaves now.
        fifo_drains_s  = (fifo_count_s == 2'd0) |
                         ((fifo_count_s == 2'd1) & m_acc_s);
        flush_done_s   = (state_q == FLUSH) & ~inflight_q & fifo_drains_s &
                         (emitted_next_s == FRAME_WORDS);
        // A pulse landing exactly as the frame finishes starts the next frame.
        overrun_s      = buffer_ready_i & (state_q != IDLE) & ~flush_done_s;
    end

    // Next-state logic: frame sequencing, read bookkeeping, counters.
    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q + {{ADDR_WIDTH{1'b0}}, rd_acc_s};
        emitted_d       = emitted_next_s;
        inflight_d      = rd_acc_s;
        inflight_idx_d  = inflight_idx_q;
        frame_count_d   = frame_count_q;
        overrun_count_d = overrun_count_q;
        overrun_d       = 1'b0;
        skid_clear_s    = 1'b0;

        if (rd_acc_s) begin
            inflight_idx_d = issued_q[ADDR_WIDTH-1:0];
        end else begin
            inflight_idx_d = inflight_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (buffer_ready_i) begin
                    state_d   = DRAIN;
                    issued_d  = '0;
                    emitted_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN, FLUSH: begin
                if (overrun_s) begin
                    // Abandon the partial frame: drop held and in-flight words
                    // and restart reading the freshly swapped buffer at word 0.
                    state_d      = DRAIN;
                    issued_d     = '0;
                    emitted_d    = '0;
                    inflight_d   = 1'b0;
                    skid_clear_s = 1'b1;
                    overrun_d    = 1'b1;
                    if (overrun_count_q != CNT_MAX) begin
                        overrun_count_d = overrun_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        overrun_count_d = overrun_count_q;
                    end
                end else if (state_q == DRAIN) begin
                    if (issued_d == FRAME_WORDS) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (flush_done_s) begin
                    frame_count_d = frame_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    if (buffer_ready_i) begin
                        state_d   = DRAIN;
                        issued_d  = '0;
                        emitted_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d      = IDLE;
                issued_d     = '0;
                emitted_d    = '0;
                inflight_d   = 1'b0;
                skid_clear_s = 1'b1;
            end
        endcase
    end

    // State, counters and the registered overrun pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            issued_q        <= '0;
            emitted_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_idx_q  <= '0;
            frame_count_q   <= '0;
            overrun_count_q <= '0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            issued_q        <= issued_d;
            emitted_q       <= emitted_d;
            inflight_q      <= inflight_d;
            inflight_idx_q  <= inflight_idx_d;
            frame_count_q   <= frame_count_d;
            overrun_count_q <= overrun_count_d;
            overrun_q       <= overrun_d;
        end
    end

    assign bus.rd_ready     = rd_ready_s;
    assign bus.m_data       = head_data_s;
    assign bus.m_valid      = head_valid_s;
    assign bus.m_first      = head_valid_s & (head_idx_s == {ADDR_WIDTH{1'b0}});
    assign bus.m_last       = head_valid_s & (head_idx_s == LAST_IDX);
    assign busy_o           = (state_q != IDLE);
    assign frame_count_o    = frame_count_q;
    assign overrun_count_o  = overrun_count_q;
    assign overrun_o        = overrun_q;

endmodule
